// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
//   rx_state_t     : deframer states
//   FRAME_BITS     : bits in a device-to-host frame (start, 8 data, parity, stop)
//   DATA_BITS      : payload bits per frame
//   odd_parity_ok  : 1 when the data byte plus its parity bit carry an odd number of ones
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return (^b) ^ p;
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Small synchronous FIFO for received scan codes.
//   clock  : system clock
//   rst_n  : asynchronous active-low reset
//   push   : write din this cycle (dropped when full unless a pop happens too)
//   pop    : remove the head this cycle (ignored when empty)
//   din    : byte to write
//   dout   : array read at the read pointer; meaningful only when empty=0
//   empty  : no entries stored
//   full   : 2**AW entries stored
module ps2_fifo #(
    parameter int AW = 3
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    import ps2_pkg::*;

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    // A pop on a full FIFO frees the slot first, so a same-cycle push still lands.
    // A pop on an empty FIFO is ignored, so a same-cycle push leaves one entry.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign dout = mem[rptr];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// Receive-only PS/2 keyboard front end.
//   clock     : 10 MHz system clock
//   locked    : asynchronous active-low reset (PLL locked)
//   ps2_clk   : raw PS/2 clock line
//   ps2_dat   : raw PS/2 data line
//   rd        : one-cycle strobe, pops the FIFO head
//   clear     : zeroes overflow and frame_err (a same-cycle set wins)
//   data      : scan code at the FIFO head, qualify with ready
//   ready     : FIFO holds at least one scan code
//   overflow  : sticky, a good byte was dropped on a full FIFO
//   frame_err : sticky, a frame failed the parity or stop-bit check
module ps2_keyboard_rx #(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 20000,
    parameter int FIFO_AW = 3
) (
    input  logic       clock,
    input  logic       locked,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       rd,
    input  logic       clear,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);
    import ps2_pkg::*;

    localparam int FCW = $clog2(FILTER + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);

    logic           clk_s1, clk_s2;
    logic           dat_s1, dat_s2;
    logic           clk_filt;
    logic [FCW-1:0] fcnt;
    logic           fall;

    rx_state_t      state;
    logic [2:0]     bitcnt;
    logic [7:0]     sreg;
    logic           par;
    logic [TCW-1:0] tcnt;

    logic           push;
    logic           bad_frame;
    logic           fifo_empty;
    logic           fifo_full;

    // Synchronisers idle high like the bus itself.
    always_ff @(posedge clock or negedge locked) begin
        if (!locked) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered level flips only after FILTER consecutive samples disagree
    // with it; fall is raised in the same edge so it lines up with clk_filt=0.
    always_ff @(posedge clock or negedge locked) begin
        if (!locked) begin
            clk_filt <= 1'b1;
            fcnt     <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s2 == clk_filt) begin
                fcnt <= '0;
            end else if (fcnt == FCW'(FILTER - 1)) begin
                clk_filt <= clk_s2;
                fcnt     <= '0;
                fall     <= ~clk_s2;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // Deframer. The timeout counter measures cycles since the last fall while
    // a frame is open; expiry silently abandons the partial frame.
    always_ff @(posedge clock or negedge locked) begin
        if (!locked) begin
            state  <= IDLE;
            bitcnt <= '0;
            sreg   <= '0;
            par    <= 1'b0;
            tcnt   <= '0;
        end else begin
            if (state == IDLE || fall) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (fall && !dat_s2) begin
                        state  <= DATA;
                        bitcnt <= '0;
                    end
                end
                DATA: begin
                    if (fall) begin
                        sreg   <= {dat_s2, sreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'(DATA_BITS - 1)) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (fall) begin
                        par   <= dat_s2;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (fall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (state != IDLE && !fall && tcnt == TCW'(TIMEOUT - 1)) begin
                state <= IDLE;
                tcnt  <= '0;
            end
        end
    end

    assign push      = (state == STOP) && fall && dat_s2 && odd_parity_ok(sreg, par);
    assign bad_frame = (state == STOP) && fall && !(dat_s2 && odd_parity_ok(sreg, par));

    always_ff @(posedge clock or negedge locked) begin
        if (!locked) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push && fifo_full && !rd) begin
                overflow <= 1'b1;
            end else if (clear) begin
                overflow <= 1'b0;
            end
            if (bad_frame) begin
                frame_err <= 1'b1;
            end else if (clear) begin
                frame_err <= 1'b0;
            end
        end
    end

    ps2_fifo #(.AW(FIFO_AW)) u_fifo (
        .clock (clock),
        .rst_n (locked),
        .push  (push),
        .pop   (rd),
        .din   (sreg),
        .dout  (data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign ready = ~fifo_empty;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int FILTER = 4;
    localparam int DEPTH  = 8;
    localparam int SLOW   = 400;   // half period at 12.5 kHz in 10 MHz cycles
    localparam int FAST   = 25;

    logic       clock = 1'b0;
    logic       locked;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       rd;
    logic       clear;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    logic       m_ovf;
    logic       m_ferr;

    always #50 clock = ~clock;

    ps2_keyboard_rx #(.FILTER(FILTER), .TIMEOUT(20000), .FIFO_AW(3)) dut (
        .clock     (clock),
        .locked    (locked),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .rd        (rd),
        .clear     (clear),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_ovf"}, {7'd0, overflow}, {7'd0, m_ovf});
        check({tag, "_ferr"}, {7'd0, frame_err}, {7'd0, m_ferr});
    endtask

    // One device-to-host bit: data set while clk high, then clk low, then high.
    task automatic send_bit(input logic v, input int half, input bit glitch);
        @(negedge clock);
        ps2_dat = v;
        repeat (half) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (half) @(negedge clock);
        ps2_clk = 1'b1;
        if (glitch) begin
            repeat (5) @(negedge clock);
            ps2_clk = 1'b0;
            repeat (3) @(negedge clock);
            ps2_clk = 1'b1;
        end
    endtask

    // Full frame. chk_lat checks ready rises exactly one cycle after the
    // internal stop-bit fall (2+FILTER cycles after the pin edge); rd_sync
    // strobes rd in that same push cycle.
    task automatic send_frame(input logic [7:0] b, input bit par_err, input bit stop_err,
                              input int half, input bit chk_lat, input bit rd_sync,
                              input int glitch_at);
        logic [10:0] fr;
        logic        exp_before;
        fr = {~stop_err, (~^b) ^ par_err, b, 1'b0};
        for (int i = 0; i < FRAME_BITS - 1; i++) begin
            send_bit(fr[i], half, i == glitch_at);
        end
        exp_before = (exp_q.size() != 0);
        @(negedge clock);
        ps2_dat = fr[10];
        repeat (half) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (FILTER + 2) @(posedge clock);
        #1;
        if (chk_lat) check("lat_before_push", {7'd0, ready}, {7'd0, exp_before});
        if (rd_sync) rd = 1'b1;
        @(posedge clock);
        #1;
        rd = 1'b0;
        if (chk_lat) begin
            check("lat_ready", {7'd0, ready}, 8'd1);
            check("lat_data", data, b);
        end
        repeat (half) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (half) @(negedge clock);
    endtask

    // Reference: odd parity and stop=1 make a good frame; a good byte enters
    // the queue if it has room (a simultaneous rd frees a slot first).
    task automatic model_frame(input logic [7:0] b, input bit par_err, input bit stop_err,
                               input bit rd_sync);
        if (par_err || stop_err) begin
            m_ferr = 1'b1;
            if (rd_sync && exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
            if (rd_sync && exp_q.size() != 0) void'(exp_q.pop_front());
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit par_err, input bit stop_err);
        send_frame(b, par_err, stop_err, FAST, 1'b0, 1'b0, -1);
        model_frame(b, par_err, stop_err, 1'b0);
    endtask

    task automatic read_check(input string tag);
        @(negedge clock);
        if (exp_q.size() != 0) begin
            check({tag, "_ready"}, {7'd0, ready}, 8'd1);
            check({tag, "_data"}, data, exp_q.pop_front());
        end else begin
            check({tag, "_empty"}, {7'd0, ready}, 8'd0);
        end
        rd = 1'b1;
        @(negedge clock);
        rd = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int kind;
        int nrd;

        locked  = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        rd      = 1'b0;
        clear   = 1'b0;
        m_ovf   = 1'b0;
        m_ferr  = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_ready", {7'd0, ready}, 8'd0);
        check("rst_data", data, 8'h00);
        check_flags("rst");
        locked = 1'b1;
        repeat (5) @(negedge clock);

        // Good 0x1C at 12.5 kHz with latency check
        send_frame(8'h1C, 1'b0, 1'b0, SLOW, 1'b1, 1'b0, -1);
        model_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        read_check("r1c");
        read_check("r1c_after");
        check_flags("good1c");

        // Parity error
        frame(8'h1C, 1'b1, 1'b0);
        check_flags("par_err");
        read_check("par_err_rd");
        pulse_clear();
        check_flags("clear1");

        // Stop-bit error
        frame(8'h3C, 1'b0, 1'b1);
        check_flags("stop_err");
        pulse_clear();

        // Overflow: nine frames, no reads
        for (int i = 1; i <= 9; i++) frame(8'(i), 1'b0, 1'b0);
        check_flags("ovf9");
        for (int i = 0; i < 9; i++) read_check("ovf_rd");
        pulse_clear();
        check_flags("clear2");

        // Abandoned partial frame, then timeout, then 0x5A
        send_bit(1'b0, FAST, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), FAST, 1'b0);
        repeat (25000) @(negedge clock);
        frame(8'h5A, 1'b0, 1'b0);
        check_flags("timeout");
        read_check("to_rd");
        read_check("to_rd_empty");

        // Glitches while idle and mid-frame
        @(negedge clock);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clock);
        send_frame(8'hF0, 1'b0, 1'b0, FAST, 1'b0, 1'b0, 3);
        model_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        check_flags("glitch");
        read_check("gl_rd");
        read_check("gl_rd_empty");

        // Push and rd together on a full FIFO
        for (int i = 0; i < DEPTH; i++) frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        send_frame(8'h77, 1'b0, 1'b0, FAST, 1'b0, 1'b1, -1);
        model_frame(8'h77, 1'b0, 1'b0, 1'b1);
        check_flags("full_rdpush");
        for (int i = 0; i < DEPTH + 1; i++) read_check("full_rd");

        // Push and rd together on an empty FIFO
        send_frame(8'h33, 1'b0, 1'b0, FAST, 1'b1, 1'b1, -1);
        model_frame(8'h33, 1'b0, 1'b0, 1'b1);
        read_check("empty_rdpush");
        read_check("empty_rdpush_after");

        // Randomised frames, errors, reads and clears
        for (int n = 0; n < 12; n++) begin
            b    = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 5);
            frame(b, kind == 0, kind == 1);
            check_flags("rnd");
            nrd = $urandom_range(0, 2);
            for (int k = 0; k < nrd; k++) read_check("rnd_rd");
            if ($urandom_range(0, 3) == 0) begin
                pulse_clear();
                check_flags("rnd_clr");
            end
        end
        while (exp_q.size() != 0) read_check("drain");

        // Reset mid-frame with bytes queued and a flag raised
        frame(8'hA1, 1'b0, 1'b0);
        frame(8'hA2, 1'b0, 1'b0);
        frame(8'hA3, 1'b1, 1'b0);
        send_bit(1'b0, FAST, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), FAST, 1'b0);
        @(negedge clock);
        locked = 1'b0;
        #1;
        exp_q.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        check("mid_rst_ready", {7'd0, ready}, 8'd0);
        check_flags("mid_rst");
        @(negedge clock);
        locked = 1'b1;
        repeat (5) @(negedge clock);
        frame(8'h12, 1'b0, 1'b0);
        check_flags("post_rst");
        read_check("post_rst_rd");
        read_check("post_rst_empty");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
